fp_sqrt_controller: RTL and testbench

Sequencing FSM for the iterative floating-point square-root datapath. Accepts a start request, pulses the datapath load/exponent/iteration/round/write enables in order, and runs a fixed number of radix-2 recurrence steps. It short-circuits special operands (NaN, negative, ±inf, ±0) straight to result selection and reports completion with a one-cycle `done` pulse.

---
 rtl/fp_sqrt_defs_pkg.sv | 37 +++
 rtl/fp_sqrt_iter_counter.sv | 37 +++
 rtl/fp_sqrt_controller.sv | 106 ++++++++++
 tb/tb_fp_sqrt_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_defs_pkg.sv
// fp_sqrt_defs_pkg
// Shared definitions for the floating-point square-root block: controller
// state encodings, result-mux codes (also used by the datapath result mux),
// default iteration count, and the special-operand classifier.
package fp_sqrt_defs_pkg;

  typedef logic [2:0] fsm_state_t;
  typedef logic [1:0] res_sel_t;

  // 24 mantissa bits plus 2 guard bits for single precision.
  localparam int ITERS_DEFAULT     = 26;
  localparam int CNT_WIDTH_DEFAULT = 5;

  localparam fsm_state_t ST_IDLE  = 3'd0;
  localparam fsm_state_t ST_LOAD  = 3'd1;
  localparam fsm_state_t ST_CHECK = 3'd2;
  localparam fsm_state_t ST_ITER  = 3'd3;
  localparam fsm_state_t ST_ROUND = 3'd4;
  localparam fsm_state_t ST_WRITE = 3'd5;
  localparam fsm_state_t ST_DONE  = 3'd6;

  localparam res_sel_t RES_NORM = 2'b00;
  localparam res_sel_t RES_ZERO = 2'b01;
  localparam res_sel_t RES_INF  = 2'b10;
  localparam res_sel_t RES_NAN  = 2'b11;

  // Negative non-zero operands (including -inf) produce NaN; -0 keeps its
  // sign through the zero path, so zero must mask the negative check.
  function automatic res_sel_t classify(input logic nan, input logic inf,
                                        input logic zero, input logic neg);
    if (nan || (neg && !zero)) return RES_NAN;
    else if (inf)              return RES_INF;
    else if (zero)             return RES_ZERO;
    else                       return RES_NORM;
  endfunction

endpackage

// File: rtl/fp_sqrt_iter_counter.sv
// fp_sqrt_iter_counter
// Recurrence step counter. Counts up from 0 and saturates at ITERS-1.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (priority over en)
//   en         : advance one step (held once terminal count is reached)
//   cnt        : current step index
//   tc         : terminal count, high while cnt == ITERS-1
module fp_sqrt_iter_counter #(
  parameter int ITERS     = 26,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == CNT_WIDTH'(ITERS - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fp_sqrt_controller.sv
// fp_sqrt_controller
// Sequencing FSM for the iterative radix-2 square-root datapath.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start                      : operation request (honoured in IDLE only)
//   flag_nan/inf/zero/neg      : operand classification, sampled in CHECK
//   ld_en/exp_en/iter_en/
//   round_en/res_en            : one-hot datapath step enables
//   res_sel                    : result mux select, held from CHECK to CHECK
//   iter_cnt                   : current recurrence step index
//   busy                       : high outside IDLE
//   done                       : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture operand
// CHECK | classify operand, compute exponent for normal operands
// ITER  | one recurrence step per cycle, ITERS cycles
// ROUND | round to nearest even
// WRITE | load result register
// DONE  | completion pulse
module fp_sqrt_controller
  import fp_sqrt_defs_pkg::*;
#(
  parameter int ITERS     = ITERS_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flag_nan,
  input  logic                 flag_inf,
  input  logic                 flag_zero,
  input  logic                 flag_neg,
  output logic                 ld_en,
  output logic                 exp_en,
  output logic                 iter_en,
  output logic                 round_en,
  output logic                 res_en,
  output logic [1:0]           res_sel,
  output logic [CNT_WIDTH-1:0] iter_cnt,
  output logic                 busy,
  output logic                 done
);

  fsm_state_t state_q, state_d;
  res_sel_t   res_sel_q, res_sel_d;
  res_sel_t   sel_now;
  logic       in_check, normal_op, cnt_tc;

  assign sel_now   = classify(flag_nan, flag_inf, flag_zero, flag_neg);
  assign in_check  = (state_q == ST_CHECK);
  assign normal_op = in_check && (sel_now == RES_NORM);

  fp_sqrt_iter_counter #(
    .ITERS     (ITERS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (normal_op),
    .en    (state_q == ST_ITER),
    .cnt   (iter_cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    res_sel_d = res_sel_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: begin
        res_sel_d = sel_now;
        state_d   = (sel_now == RES_NORM) ? ST_ITER : ST_WRITE;
      end
      ST_ITER:  if (cnt_tc) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      res_sel_q <= RES_NORM;
    end else begin
      state_q   <= state_d;
      res_sel_q <= res_sel_d;
    end
  end

  // exp_en is the one flag-dependent output: the exponent step only runs
  // when CHECK commits to the recurrence path.
  assign ld_en    = (state_q == ST_LOAD);
  assign exp_en   = normal_op;
  assign iter_en  = (state_q == ST_ITER);
  assign round_en = (state_q == ST_ROUND);
  assign res_en   = (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign res_sel  = res_sel_q;

endmodule

// File: tb/tb_fp_sqrt_controller.sv
// tb_fp_sqrt_controller
// Drives a default (ITERS=26) and a minimal (ITERS=2) instance. Each operation
// is checked cycle by cycle against an expected timeline derived from the
// operand class and the documented cycle offsets.
module tb_fp_sqrt_controller;

  localparam int IT0 = 26;
  localparam int IT1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start [2];
  logic f_nan, f_inf, f_zero, f_neg;
  logic ld [2], ex [2], it [2], rd [2], rs [2], bz [2], dn [2];
  logic [1:0] sel [2];
  logic [4:0] cnt_a;
  logic [0:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int prev_sel [2];
  int prev_cnt [2];

  always #5 clk = ~clk;

  fp_sqrt_controller #(.ITERS(IT0), .CNT_WIDTH(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .flag_nan(f_nan), .flag_inf(f_inf), .flag_zero(f_zero), .flag_neg(f_neg),
    .ld_en(ld[0]), .exp_en(ex[0]), .iter_en(it[0]), .round_en(rd[0]),
    .res_en(rs[0]), .res_sel(sel[0]), .iter_cnt(cnt_a), .busy(bz[0]), .done(dn[0])
  );

  fp_sqrt_controller #(.ITERS(IT1), .CNT_WIDTH(1)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .flag_nan(f_nan), .flag_inf(f_inf), .flag_zero(f_zero), .flag_neg(f_neg),
    .ld_en(ld[1]), .exp_en(ex[1]), .iter_en(it[1]), .round_en(rd[1]),
    .res_en(rs[1]), .res_sel(sel[1]), .iter_cnt(cnt_b), .busy(bz[1]), .done(dn[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 0) ? {27'b0, cnt_a} : {31'b0, cnt_b};
  endfunction

  // Expected result class straight from the operand rules.
  function automatic int ref_sel(input bit nan, input bit inf, input bit zero, input bit neg);
    if (nan) return 3;
    if (neg && !zero) return 3;
    if (inf) return 2;
    if (zero) return 1;
    return 0;
  endfunction

  task automatic check_outs(input int d, input string tag,
                            input bit e_ld, input bit e_ex, input bit e_it,
                            input bit e_rd, input bit e_rs, input bit e_bz,
                            input bit e_dn, input int e_sel, input int e_cnt);
    check({tag, "/ld"},   ld[d], e_ld);
    check({tag, "/exp"},  ex[d], e_ex);
    check({tag, "/iter"}, it[d], e_it);
    check({tag, "/rnd"},  rd[d], e_rd);
    check({tag, "/res"},  rs[d], e_rs);
    check({tag, "/busy"}, bz[d], e_bz);
    check({tag, "/done"}, dn[d], e_dn);
    check({tag, "/sel"},  sel[d], e_sel);
    check({tag, "/cnt"},  cnt_of(d), e_cnt);
  endtask

  task automatic rand_flags();
    {f_nan, f_inf, f_zero, f_neg} = 4'($urandom_range(0, 15));
  endtask

  // One operation on instance d. rst_k >= 0 asserts reset right after the
  // check of cycle rst_k and abandons the operation.
  task automatic run_op(input int d, input bit hold,
                        input bit nan, input bit inf, input bit zero, input bit neg,
                        input int rst_k);
    int iters, s, last, e_cnt;
    bit special;
    string tag;
    iters   = (d == 0) ? IT0 : IT1;
    s       = ref_sel(nan, inf, zero, neg);
    special = (s != 0);
    last    = special ? 4 : iters + 5;

    @(posedge clk); #1;
    start[d] = 1'b1;
    rand_flags();
    @(negedge clk);
    check_outs(d, $sformatf("d%0d k0", d), 0, 0, 0, 0, 0, 0, 0, prev_sel[d], prev_cnt[d]);

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start[d] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == 2) {f_nan, f_inf, f_zero, f_neg} = {nan, inf, zero, neg};
      else        rand_flags();
      @(negedge clk);
      if (special || k <= 2)    e_cnt = prev_cnt[d];
      else if (k <= iters + 2)  e_cnt = k - 3;
      else                      e_cnt = iters - 1;
      tag = $sformatf("d%0d s%0d k%0d", d, s, k);
      check_outs(d, tag,
                 k == 1,
                 !special && k == 2,
                 !special && k >= 3 && k <= iters + 2,
                 !special && k == iters + 3,
                 k == last - 1,
                 1'b1,
                 k == last,
                 (k >= 3) ? s : prev_sel[d],
                 e_cnt);
      if (k == rst_k) begin
        #1 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++)
          check_outs(j, $sformatf("async_rst d%0d", j), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        prev_sel[0] = 0; prev_sel[1] = 0;
        prev_cnt[0] = 0; prev_cnt[1] = 0;
        start[d] = 1'b0;
        return;
      end
    end
    prev_sel[d] = s;
    if (!special) prev_cnt[d] = iters - 1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      rand_flags();
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        check($sformatf("gap d%0d busy", j), bz[j], 0);
        check($sformatf("gap d%0d done", j), dn[j], 0);
        check($sformatf("gap d%0d sel", j), sel[j], prev_sel[j]);
      end
    end
  endtask

  initial begin
    bit n, i, z, g;
    rst_n = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    {f_nan, f_inf, f_zero, f_neg} = 4'b0;
    for (int j = 0; j < 2; j++) begin
      prev_sel[j] = 0;
      prev_cnt[j] = 0;
    end

    #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++)
      check_outs(j, $sformatf("reset d%0d", j), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap(2);

    // Normal operand (e.g. 4.0), then each special class.
    run_op(0, 0, 0, 0, 0, 0, -1);
    idle_gap(1);
    run_op(0, 0, 1, 0, 0, 0, -1);
    run_op(0, 0, 0, 0, 0, 1, -1);
    run_op(0, 0, 0, 1, 0, 0, -1);
    run_op(0, 0, 0, 0, 1, 1, -1);
    run_op(0, 0, 0, 1, 0, 1, -1);
    run_op(0, 0, 0, 0, 1, 0, -1);
    idle_gap(1);

    // start held high: back-to-back operations every ITERS+6 cycles.
    run_op(0, 1, 0, 0, 0, 0, -1);
    run_op(0, 1, 0, 0, 0, 0, -1);
    run_op(0, 1, 0, 0, 0, 0, -1);
    idle_gap(1);

    // Reset mid-iteration at iter_cnt == 10 (cycle 13), then a fresh op.
    run_op(0, 0, 1, 0, 0, 0, -1);
    run_op(0, 0, 0, 0, 0, 0, 13);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap(1);
    run_op(0, 0, 0, 0, 0, 0, -1);

    // Minimal-iteration instance.
    idle_gap(1);
    run_op(1, 0, 0, 0, 0, 0, -1);
    run_op(1, 0, 0, 1, 0, 0, -1);
    run_op(1, 1, 0, 0, 0, 0, -1);
    run_op(1, 0, 0, 0, 0, 0, -1);
    idle_gap(1);

    // Randomized operations across both instances.
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 1) == 0) {n, i, z, g} = 4'b0;
      else {n, i, z, g} = 4'($urandom_range(0, 15));
      run_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, i, z, g, -1);
      idle_gap(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
